// File: rtl/bit_rev_reorder_pkg.sv
// Shared types and helpers for the FFT output reorder stage.
package bit_rev_reorder_pkg;

    // Read-side sequencer states
    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } rd_state_t;

    // Reverse the n LSBs of k; same index mapping as the R2SDF shuffle generator.
    function automatic logic [31:0] rev_bit(input logic [31:0] k, input int n);
        logic [31:0] r;
        logic [31:0] x;
        r = '0;
        x = k;
        for (int i = 0; i < n; i++) begin
            r = {r[30:0], x[0]};
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_rev_reorder_ram.sv
// Ping-pong frame store: two banks of 2^N complex samples, sync write, async read.
module reorder_ram
    import bit_rev_reorder_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [N:0]    wa,
    input  logic [CW-1:0] wd,
    input  logic [N:0]    ra,
    output logic [CW-1:0] rd
);

    logic [CW-1:0] mem [2**(N+1)];

    // Write port; address MSB selects the bank
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    assign rd = mem[ra];

endmodule

// File: rtl/bit_rev_reorder.sv
// Converts bit-reversed FFT frames into natural bin order via a ping-pong buffer.
module bit_rev_reorder
    import bit_rev_reorder_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_sof,
    output logic [N-1:0]  out_idx
);

    localparam int CW = 2 * DW;

    // Write side
    logic [N-1:0] wr_cnt;
    logic         wr_bank;
    logic         wr_done;
    logic [1:0]   set_full;

    // Bank handshake and read side
    logic [1:0]   bank_full;
    logic [1:0]   clr_full;
    rd_state_t    st, st_nxt;
    logic         rd_bank, rd_bank_nxt;
    logic [N-1:0] rd_cnt, rd_cnt_nxt;
    logic         other;
    logic         issue;

    logic [31:0]  rev_full;
    logic         unused_rev_hi;
    logic [CW-1:0] rd_data;

    assign wr_done  = in_valid && (wr_cnt == '1);
    assign set_full = wr_done ? (2'b01 << wr_bank) : 2'b00;
    assign other    = ~rd_bank;

    // Natural bin rd_cnt lives at stream position rev(rd_cnt)
    assign rev_full      = rev_bit(32'(rd_cnt), N);
    assign unused_rev_hi = ^rev_full[31:N];

    reorder_ram #(.N(N), .CW(CW)) u_ram (
        .clk (clk),
        .we  (in_valid),
        .wa  ({wr_bank, wr_cnt}),
        .wd  ({in_re, in_im}),
        .ra  ({rd_bank, rev_full[N-1:0]}),
        .rd  (rd_data)
    );

    // Write counter; bank flips on the edge that stores the last sample of a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (in_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_done)
                wr_bank <= ~wr_bank;
        end
    end

    // Full flags: writer sets on frame completion, reader clears when it claims a bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bank_full <= 2'b00;
        else
            bank_full <= (bank_full & ~clr_full) | set_full;
    end

    // Read sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_IDLE;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            st      <= st_nxt;
            rd_bank <= rd_bank_nxt;
            rd_cnt  <= rd_cnt_nxt;
        end
    end

    // Next-state: idle reads bin 0 as soon as the expected bank is full, so
    // bin 0 leaves one edge after the frame's last write. rd_cnt is always 0
    // in idle because a read pass ends by wrapping it.
    always_comb begin
        st_nxt      = st;
        rd_bank_nxt = rd_bank;
        rd_cnt_nxt  = rd_cnt;
        clr_full    = 2'b00;
        issue       = 1'b0;
        unique case (st)
            S_IDLE: begin
                if (bank_full[rd_bank]) begin
                    issue             = 1'b1;
                    clr_full[rd_bank] = 1'b1;
                    rd_cnt_nxt        = rd_cnt + 1'b1;
                    st_nxt            = S_READ;
                end
            end
            S_READ: begin
                issue      = 1'b1;
                rd_cnt_nxt = rd_cnt + 1'b1;
                if (rd_cnt == '1) begin
                    rd_bank_nxt = other;
                    if (bank_full[other])
                        clr_full[other] = 1'b1;
                    else
                        st_nxt = S_IDLE;
                end
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    // Output register; data and index hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_idx   <= '0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_sof   <= (rd_cnt == '0);
            out_idx   <= rd_cnt;
            out_re    <= rd_data[CW-1:DW];
            out_im    <= rd_data[DW-1:0];
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_rev_reorder.sv
// Self-checking bench for bit_rev_reorder with a per-cycle output schedule model.
module tb_bit_rev_reorder;

    localparam int N   = 3;
    localparam int DW  = 16;
    localparam int LEN = 1 << N;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          out_sof;
    logic [N-1:0]  out_idx;

    bit_rev_reorder #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_sof   (out_sof),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int next_free = 0;

    // Model: collected input frame, and expected output keyed by edge number
    logic [DW-1:0] q_re[$];
    logic [DW-1:0] q_im[$];
    logic [DW-1:0] exp_re[int];
    logic [DW-1:0] exp_im[int];
    int            exp_idx[int];

    function automatic int rev(input int k);
        int r = 0;
        int x = k;
        for (int i = 0; i < N; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Stream position p holds bin rev(p); frame done at edge E puts bin k on edge E+1+k
    task automatic model_write(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int start;
        q_re.push_back(re);
        q_im.push_back(im);
        if (q_re.size() == LEN) begin
            start = (cyc + 1 > next_free) ? cyc + 1 : next_free;
            for (int p = 0; p < LEN; p++) begin
                exp_re[start + rev(p)]  = q_re[p];
                exp_im[start + rev(p)]  = q_im[p];
                exp_idx[start + rev(p)] = rev(p);
            end
            next_free = start + LEN;
            q_re.delete();
            q_im.delete();
        end
    endtask

    task automatic check_out();
        if (exp_re.exists(cyc)) begin
            chk("valid", 32'(out_valid), 32'd1);
            chk("re",    32'(out_re),    32'(exp_re[cyc]));
            chk("im",    32'(out_im),    32'(exp_im[cyc]));
            chk("idx",   32'(out_idx),   32'(exp_idx[cyc]));
            chk("sof",   32'(out_sof),   32'(exp_idx[cyc] == 0));
        end else begin
            chk("idle_valid", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im);
        in_valid = v;
        in_re    = re;
        in_im    = im;
        @(posedge clk);
        cyc++;
        if (v)
            model_write(re, im);
        @(negedge clk);
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, '0, '0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_sof"},   32'(out_sof),   32'd0);
        chk({tag, "_idx"},   32'(out_idx),   32'd0);
        chk({tag, "_re"},    32'(out_re),    32'd0);
        chk({tag, "_im"},    32'(out_im),    32'd0);
    endtask

    // Asynchronous pulse placed between edges; the model forgets everything
    task automatic pulse_reset(input string tag);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outs(tag);
        q_re.delete();
        q_im.delete();
        exp_re.delete();
        exp_im.delete();
        exp_idx.delete();
        next_free = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_reset_outs({tag, "_held"});
        #2 rst_n = 1'b1;
    endtask

    int gaps [8] = '{0, 2, 0, 1, 3, 0, 0, 1};
    bit found;
    logic [DW-1:0] rr, ri;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        #1 check_reset_outs("rst0");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // 1: single frame, bin rev(p) at position p
        for (int p = 0; p < LEN; p++)
            step(1'b1, DW'(rev(p)), DW'(rev(p) + 100));
        idle(10);

        // 2: three back-to-back frames
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < LEN; p++)
                step(1'b1, DW'(rev(p) + 8 * f), DW'(rev(p) + 8 * f + 100));
        idle(10);

        // 3: same frame with irregular input gaps
        for (int p = 0; p < LEN; p++) begin
            idle(gaps[p]);
            step(1'b1, DW'(rev(p)), DW'(rev(p) + 100));
        end
        idle(10);

        // 4: reset after a partial frame, then one clean frame
        for (int p = 0; p < 5; p++)
            step(1'b1, DW'(16'h0EE0 + p), DW'(16'h0FF0 + p));
        pulse_reset("t4_rst");
        idle(3);
        for (int p = 0; p < LEN; p++)
            step(1'b1, DW'(rev(p) + 40), DW'(rev(p) + 140));
        idle(10);

        // 5: reset while bin 3 is on the outputs
        for (int p = 0; p < LEN; p++)
            step(1'b1, DW'($urandom), DW'($urandom));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid === 1'b1 && out_idx === 3'd3)
                found = 1'b1;
            else
                step(1'b0, '0, '0);
        end
        chk("t5_reach_idx3", 32'(found), 32'd1);
        pulse_reset("t5_rst");
        idle(12);
        for (int p = 0; p < LEN; p++)
            step(1'b1, DW'($urandom), DW'($urandom));
        idle(10);

        // 6: extreme values at stream position 1 (bin 4)
        for (int p = 0; p < LEN; p++) begin
            if (p == 1)
                step(1'b1, 16'h8000, 16'h7FFF);
            else
                step(1'b1, DW'($urandom), DW'($urandom));
        end
        idle(10);

        // Random frames: some continuous, some with random gaps
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < LEN; p++) begin
                if (f >= 3)
                    idle($urandom_range(0, 2));
                rr = DW'($urandom);
                ri = DW'($urandom);
                step(1'b1, rr, ri);
            end
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
